// File: rtl/centroid_div_scheduler_pkg.sv
// Shared widths, frame limits and scheduler state encoding for the k-means
// centroid divide pass.
package kmeans_pkg;
    localparam int NUM_CENTROIDS = 7;
    localparam int FRAME_WIDTH   = 320;
    localparam int FRAME_HEIGHT  = 180;
    localparam int COORD_X_W     = 9;
    localparam int COORD_Y_W     = 8;
    localparam int SUM_W         = 24;
    localparam int DIV_WIDTH     = SUM_W;
    localparam int NB_W          = 3;
    localparam int JOB_W         = 4;

    typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT, NEXT, DONE} div_sched_state_t;
endpackage

// File: rtl/centroid_div_scheduler_if.sv
// Request/result bundle between the iteration controller and the divide scheduler.
interface centroid_div_scheduler_if;
    import kmeans_pkg::*;

    logic                                       start_in;
    logic [NB_W-1:0]                            num_balls_in;
    logic [NUM_CENTROIDS-1:0][COORD_X_W-1:0]    centroids_x_in;
    logic [NUM_CENTROIDS-1:0][COORD_Y_W-1:0]    centroids_y_in;
    logic [NUM_CENTROIDS-1:0][SUM_W-1:0]        x_sum_in;
    logic [NUM_CENTROIDS-1:0][SUM_W-1:0]        y_sum_in;
    logic [NUM_CENTROIDS-1:0][SUM_W-1:0]        mass_in;
    logic                                       busy_out;
    logic                                       done_out;
    logic                                       converged_out;
    logic [NUM_CENTROIDS-1:0][COORD_X_W-1:0]    centroids_x_out;
    logic [NUM_CENTROIDS-1:0][COORD_Y_W-1:0]    centroids_y_out;

    modport master (
        output start_in, num_balls_in, centroids_x_in, centroids_y_in,
               x_sum_in, y_sum_in, mass_in,
        input  busy_out, done_out, converged_out, centroids_x_out, centroids_y_out
    );

    modport slave (
        input  start_in, num_balls_in, centroids_x_in, centroids_y_in,
               x_sum_in, y_sum_in, mass_in,
        output busy_out, done_out, converged_out, centroids_x_out, centroids_y_out
    );
endinterface

// File: rtl/centroid_div_scheduler_divider.sv
// Iterative restoring unsigned divider: one quotient bit per cycle, one request
// in flight, divide-by-zero reported through error_out.
module divider #(
    parameter int WIDTH = 24
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             data_valid_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient_out,
    output logic             data_valid_out,
    output logic             error_out,
    output logic             busy_out
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]  cnt;
    logic [WIDTH:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0] shifted;
    logic           ge;

    // Partial remainder is one bit wider so the shifted value never overflows.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvsr};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            dvsr           <= '0;
            busy_out       <= 1'b0;
            data_valid_out <= 1'b0;
            error_out      <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (!busy_out) begin
                if (data_valid_in) begin
                    if (divisor_in == '0) begin
                        quo            <= '0;
                        rem            <= '0;
                        error_out      <= 1'b1;
                        data_valid_out <= 1'b1;
                    end else begin
                        quo       <= dividend_in;
                        rem       <= '0;
                        dvsr      <= divisor_in;
                        cnt       <= '0;
                        error_out <= 1'b0;
                        busy_out  <= 1'b1;
                    end
                end
            end else begin
                rem <= ge ? shifted - {1'b0, dvsr} : shifted;
                quo <= {quo[WIDTH-2:0], ge};
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    busy_out       <= 1'b0;
                    data_valid_out <= 1'b1;
                end
            end
        end
    end

    assign quotient_out = quo;
endmodule

// File: rtl/centroid_div_scheduler.sv
// Time-shares a single divider over every centroid x/y division of a k-means
// iteration and reports new centroids plus a convergence flag.
module centroid_div_scheduler
    import kmeans_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    centroid_div_scheduler_if.slave  bus
);
    div_sched_state_t state_q, state_d;

    logic [JOB_W-1:0] job_q;
    logic [NB_W-1:0]  n_q;
    logic [NUM_CENTROIDS-1:0][COORD_X_W-1:0] px_q, cx_q;
    logic [NUM_CENTROIDS-1:0][COORD_Y_W-1:0] py_q, cy_q;
    logic [NUM_CENTROIDS-1:0][SUM_W-1:0]     xs_q, ys_q, ms_q;
    logic busy_q, done_q, conv_q;

    logic                 div_valid;
    logic [DIV_WIDTH-1:0] div_quo;
    logic                 div_dv, div_err, div_busy;

    logic [NB_W-1:0]      cidx;
    logic                 is_y;
    logic [SUM_W-1:0]     cur_sum, cur_mass;
    logic [JOB_W-1:0]     last_job;
    logic                 accept;
    logic [COORD_X_W-1:0] x_sat;
    logic [COORD_Y_W-1:0] y_sat;
    logic [NUM_CENTROIDS-1:0] same;

    // Even jobs divide x, odd jobs divide y, of centroid job/2.
    assign cidx     = job_q[JOB_W-1:1];
    assign is_y     = job_q[0];
    assign cur_sum  = is_y ? ys_q[cidx] : xs_q[cidx];
    assign cur_mass = ms_q[cidx];
    assign last_job = {n_q - 1'b1, 1'b1};
    assign accept   = bus.start_in && !busy_q;

    assign x_sat = (div_quo > DIV_WIDTH'(FRAME_WIDTH - 1))
                 ? COORD_X_W'(FRAME_WIDTH - 1) : div_quo[COORD_X_W-1:0];
    assign y_sat = (div_quo > DIV_WIDTH'(FRAME_HEIGHT - 1))
                 ? COORD_Y_W'(FRAME_HEIGHT - 1) : div_quo[COORD_Y_W-1:0];

    // Inactive centroids never block convergence.
    for (genvar i = 0; i < NUM_CENTROIDS; i++) begin : g_conv
        assign same[i] = (i >= int'(n_q)) || ((cx_q[i] == px_q[i]) && (cy_q[i] == py_q[i]));
    end

    divider #(.WIDTH(DIV_WIDTH)) u_div (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .data_valid_in  (div_valid),
        .dividend_in    (cur_sum),
        .divisor_in     (cur_mass),
        .quotient_out   (div_quo),
        .data_valid_out (div_dv),
        .error_out      (div_err),
        .busy_out       (div_busy)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        div_valid = 1'b0;
        case (state_q)
            IDLE:   if (accept) state_d = (bus.num_balls_in == '0) ? DONE : SELECT;
            SELECT: state_d = (cur_mass == '0) ? NEXT : ISSUE;
            ISSUE:  if (!div_busy) begin
                        div_valid = 1'b1;
                        state_d   = WAIT;
                    end
            WAIT:   if (div_dv) state_d = NEXT;
            NEXT:   state_d = (job_q == last_job) ? DONE : SELECT;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            job_q  <= '0;
            n_q    <= '0;
            px_q   <= '0;
            py_q   <= '0;
            xs_q   <= '0;
            ys_q   <= '0;
            ms_q   <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            conv_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    n_q    <= bus.num_balls_in;
                    px_q   <= bus.centroids_x_in;
                    py_q   <= bus.centroids_y_in;
                    xs_q   <= bus.x_sum_in;
                    ys_q   <= bus.y_sum_in;
                    ms_q   <= bus.mass_in;
                    cx_q   <= bus.centroids_x_in;
                    cy_q   <= bus.centroids_y_in;
                    job_q  <= '0;
                    busy_q <= 1'b1;
                end
                SELECT: if (cur_mass == '0) begin
                    if (is_y) cy_q[cidx] <= py_q[cidx];
                    else      cx_q[cidx] <= px_q[cidx];
                end
                WAIT: if (div_dv) begin
                    if (is_y) cy_q[cidx] <= div_err ? py_q[cidx] : y_sat;
                    else      cx_q[cidx] <= div_err ? px_q[cidx] : x_sat;
                end
                NEXT: if (job_q != last_job) job_q <= job_q + 1'b1;
                DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    conv_q <= &same;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_out        = busy_q;
    assign bus.done_out        = done_q;
    assign bus.converged_out   = conv_q;
    assign bus.centroids_x_out = cx_q;
    assign bus.centroids_y_out = cy_q;
endmodule

// File: tb/tb_centroid_div_scheduler.sv
// Directed scoreboard bench for centroid_div_scheduler: stimulus queues the
// expected pass result, a monitor checks it on every done_out.
module tb_centroid_div_scheduler;
    import kmeans_pkg::*;

    typedef struct packed {
        logic [NUM_CENTROIDS-1:0][COORD_X_W-1:0] x;
        logic [NUM_CENTROIDS-1:0][COORD_Y_W-1:0] y;
        logic                                    conv;
    } exp_t;

    logic clk_in, rst_in;
    int   checks = 0;
    int   errors = 0;
    int   req_cnt = 0;
    exp_t sb[$];

    centroid_div_scheduler_if bus ();

    centroid_div_scheduler dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) if (dut.div_valid) req_cnt++;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done_out must match the oldest queued expectation.
    initial forever begin
        exp_t e;
        @(negedge clk_in);
        if (bus.done_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("x_out", 128'(bus.centroids_x_out), 128'(e.x));
                check("y_out", 128'(bus.centroids_y_out), 128'(e.y));
                check("converged", 128'(bus.converged_out), 128'(e.conv));
                check("busy_at_done", 128'(bus.busy_out), 0);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk_in); bus.start_in = 1'b1;
        @(negedge clk_in); bus.start_in = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int base, input int exp_reqs);
        int cyc = 0;
        while (bus.busy_out && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
        end
        if (bus.busy_out) check({nm, "_timeout"}, 1, 0);
        repeat (2) @(negedge clk_in);
        check({nm, "_div_reqs"}, 128'(req_cnt - base), 128'(exp_reqs));
        check({nm, "_pending"}, 128'(sb.size()), 0);
    endtask

    task automatic clear_inputs();
        bus.num_balls_in   = '0;
        bus.centroids_x_in = '0;
        bus.centroids_y_in = '0;
        bus.x_sum_in       = '0;
        bus.y_sum_in       = '0;
        bus.mass_in        = '0;
    endtask

    task automatic garbage_prev();
        for (int i = 0; i < NUM_CENTROIDS; i++) begin
            bus.centroids_x_in[i] = 9'(10 + i);
            bus.centroids_y_in[i] = 8'(20 + i);
            bus.x_sum_in[i]       = 24'(777 + i);
            bus.y_sum_in[i]       = 24'(555 + i);
            bus.mass_in[i]        = 24'(3 + i);
        end
    endtask

    initial begin
        exp_t e;
        int   base;
        bus.start_in = 1'b0;
        clear_inputs();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("rst_busy", 128'(bus.busy_out), 0);
        check("rst_done", 128'(bus.done_out), 0);
        check("rst_conv", 128'(bus.converged_out), 0);
        check("rst_x", 128'(bus.centroids_x_out), 0);
        check("rst_y", 128'(bus.centroids_y_out), 0);

        // N=1: 1000/10, 500/10; inactive centroids keep snapshot.
        garbage_prev();
        bus.num_balls_in = 3'd1;
        bus.centroids_x_in[0] = 9'd0; bus.centroids_y_in[0] = 8'd0;
        bus.x_sum_in[0] = 24'd1000; bus.y_sum_in[0] = 24'd500; bus.mass_in[0] = 24'd10;
        e.x = bus.centroids_x_in; e.y = bus.centroids_y_in;
        e.x[0] = 9'd100; e.y[0] = 8'd50; e.conv = 1'b0;
        sb.push_back(e); base = req_cnt;
        pulse_start();
        wait_idle("n1", base, 2);

        // N=2 with empty centroid 1: fallback to (37,21), only c0 divides.
        garbage_prev();
        bus.num_balls_in = 3'd2;
        bus.centroids_x_in[0] = 9'd0; bus.centroids_y_in[0] = 8'd0;
        bus.x_sum_in[0] = 24'd600; bus.y_sum_in[0] = 24'd300; bus.mass_in[0] = 24'd20;
        bus.centroids_x_in[1] = 9'd37; bus.centroids_y_in[1] = 8'd21; bus.mass_in[1] = 24'd0;
        e.x = bus.centroids_x_in; e.y = bus.centroids_y_in;
        e.x[0] = 9'd30; e.y[0] = 8'd15; e.conv = 1'b0;
        sb.push_back(e); base = req_cnt;
        pulse_start();
        wait_idle("n2_empty", base, 2);

        // N=7, sums = prev*mass: everything unchanged, converged.
        for (int i = 0; i < NUM_CENTROIDS; i++) begin
            bus.centroids_x_in[i] = 9'(40 * i + 7);
            bus.centroids_y_in[i] = 8'(25 * i + 3);
            bus.mass_in[i]        = 24'(1000 * i + 3);
            bus.x_sum_in[i]       = 24'((40 * i + 7) * (1000 * i + 3));
            bus.y_sum_in[i]       = 24'((25 * i + 3) * (1000 * i + 3));
        end
        bus.num_balls_in = 3'd7;
        e.x = bus.centroids_x_in; e.y = bus.centroids_y_in; e.conv = 1'b1;
        sb.push_back(e); base = req_cnt;
        pulse_start();
        wait_idle("n7_conv", base, 14);

        // Saturation to frame edges.
        garbage_prev();
        bus.num_balls_in = 3'd1;
        bus.centroids_x_in[0] = 9'd5; bus.centroids_y_in[0] = 8'd5;
        bus.x_sum_in[0] = 24'd400000; bus.y_sum_in[0] = 24'd250; bus.mass_in[0] = 24'd1;
        e.x = bus.centroids_x_in; e.y = bus.centroids_y_in;
        e.x[0] = 9'd319; e.y[0] = 8'd179; e.conv = 1'b0;
        sb.push_back(e); base = req_cnt;
        pulse_start();
        wait_idle("sat", base, 2);

        // start re-pulsed mid-divide with new inputs: ignored, one done only.
        garbage_prev();
        bus.num_balls_in = 3'd1;
        bus.centroids_x_in[0] = 9'd0; bus.centroids_y_in[0] = 8'd0;
        bus.x_sum_in[0] = 24'd900; bus.y_sum_in[0] = 24'd270; bus.mass_in[0] = 24'd9;
        e.x = bus.centroids_x_in; e.y = bus.centroids_y_in;
        e.x[0] = 9'd100; e.y[0] = 8'd30; e.conv = 1'b0;
        sb.push_back(e); base = req_cnt;
        pulse_start();
        repeat (6) @(negedge clk_in);
        bus.num_balls_in = 3'd3;
        bus.x_sum_in[0] = 24'd5000; bus.mass_in[0] = 24'd2;
        pulse_start();
        wait_idle("restart_ignored", base, 2);

        // N=0: done two cycles after start, converged, no divider use.
        garbage_prev();
        bus.num_balls_in = 3'd0;
        e.x = bus.centroids_x_in; e.y = bus.centroids_y_in; e.conv = 1'b1;
        sb.push_back(e); base = req_cnt;
        @(negedge clk_in); bus.start_in = 1'b1;
        @(negedge clk_in); bus.start_in = 1'b0;
        check("n0_done_early", 128'(bus.done_out), 0);
        @(negedge clk_in);
        check("n0_done_at_2", 128'(bus.done_out), 1);
        wait_idle("n0", base, 0);

        // Reset in the middle of a divide: outputs cleared, no done afterwards.
        garbage_prev();
        bus.num_balls_in = 3'd2;
        pulse_start();
        repeat (6) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("midrst_busy", 128'(bus.busy_out), 0);
        check("midrst_done", 128'(bus.done_out), 0);
        check("midrst_x", 128'(bus.centroids_x_out), 0);
        check("midrst_y", 128'(bus.centroids_y_out), 0);
        rst_in = 1'b0;
        repeat (150) @(negedge clk_in);
        check("midrst_idle_busy", 128'(bus.busy_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
